dram_axi_bridge: RTL and testbench

Single-clock bridge from the core's 32-bit word request interface (rd/wr, address, data, byte strobes) to an AXI4 master port on the MIG/interconnect. It is the parametrised successor of the unbuffered, one-request-at-a-time DRAM controller. Adds configurable AXI beat width, a posted-write queue of configurable depth, read-after-write ordering, and error reporting.

---
 rtl/dram_bridge_pkg.sv | 33 +++
 rtl/dram_axi_bridge_if.sv | 74 +++++++
 rtl/sync_fifo.sv | 47 ++++
 rtl/dram_axi_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_dram_axi_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_bridge_pkg.sv
// Shared constants for the DRAM AXI bridge.
//   - AXI burst/response codes and fixed attribute tie-offs
//   - Front (request) and write-engine FSM state encodings
//   - beat_lsb(): byte-offset width of one AXI beat
package dram_bridge_pkg;

    localparam int unsigned ID_W = 4;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_CACHE   = 4'b0011;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Front FSM
    localparam logic [2:0] StCalib  = 3'd0;
    localparam logic [2:0] StIdle   = 3'd1;
    localparam logic [2:0] StRdrain = 3'd2;
    localparam logic [2:0] StRaddr  = 3'd3;
    localparam logic [2:0] StRdata  = 3'd4;

    // Write engine FSM
    localparam logic [1:0] WStIdle  = 2'd0;
    localparam logic [1:0] WStReq   = 2'd1;
    localparam logic [1:0] WStResp  = 2'd2;

    function automatic int unsigned beat_lsb(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dram_axi_bridge_if.sv
// Single-beat AXI4 bus between the bridge (master) and the MIG/interconnect (slave).
//   AW/W/B: write address, data, response.  AR/R: read address, data.
interface dram_axi_bridge_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
);
    import dram_bridge_pkg::*;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   push_i/wdata_i : enqueue (ignored when full unless popping in the same cycle)
//   pop_i          : dequeue head (ignored when empty)
//   rdata_o        : current head entry
//   full_o/empty_o : occupancy flags
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PTR_W:0]   wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + {{PTR_W{1'b0}}, 1'b1};
            if (do_pop)  rptr_q <= rptr_q + {{PTR_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/dram_axi_bridge.sv
// Bridge from the core's 32-bit word request port to a single-beat AXI4 master.
//   i_clk, i_rst        : clock, async active-high reset
//   i_calib_done        : DRAM calibration complete (first rise releases the bridge)
//   i_rd_en/i_wr_en     : requests, sampled while o_busy=0 (write wins if both)
//   i_addr/i_data/i_wstrb: byte address, write word, byte enables
//   o_busy              : requests ignored this cycle
//   o_rdata/o_rvalid    : full read beat with one-cycle valid pulse
//   o_err               : sticky SLVERR/DECERR flag
//   m_axi               : AXI4 master port
// Writes are posted into a queue and drained one at a time; a read waits for the
// queue and the write engine to go idle so it always observes earlier writes.
module dram_axi_bridge
    import dram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned QDEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_calib_done,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_data,
    input  logic [3:0]        i_wstrb,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_err,
    dram_axi_bridge_if.master m_axi
);
    localparam int unsigned LSB     = beat_lsb(DATA_W);
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W + STRB_W;

    // Request lane mapping
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] strb_base, req_wstrb;

    assign req_addr  = {i_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
    assign req_wdata = {(DATA_W/32){i_data}};

    always_comb begin
        strb_base      = '0;
        strb_base[3:0] = i_wstrb;
    end

    if (LSB > 2) begin : g_lane
        assign req_wstrb = strb_base << {i_addr[LSB-1:2], 2'b00};
    end else begin : g_no_lane
        assign req_wstrb = strb_base;
    end

    if (ADDR_W < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^i_addr[31:ADDR_W];
    end
    logic unused_lo;
    assign unused_lo = ^{i_addr[1:0], m_axi.bresp[0], m_axi.rresp[0]};

    // Posted-write queue
    logic               q_push, q_pop, q_full, q_empty;
    logic [ENTRY_W-1:0] q_head;

    sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(QDEPTH)
    ) u_wq (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .push_i (q_push),
        .pop_i  (q_pop),
        .wdata_i({req_addr, req_wdata, req_wstrb}),
        .rdata_o(q_head),
        .full_o (q_full),
        .empty_o(q_empty)
    );

    // Front FSM
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] raddr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q, err_q;
    logic              rd_accept;
    logic [1:0]        wstate_q, wstate_d;

    assign o_busy = (state_q != StIdle) || q_full;

    always_comb begin
        state_d   = state_q;
        q_push    = 1'b0;
        rd_accept = 1'b0;
        case (state_q)
            StCalib:  if (i_calib_done) state_d = StIdle;
            StIdle: begin
                if (!q_full) begin
                    if (i_wr_en) begin
                        q_push = 1'b1;
                    end else if (i_rd_en) begin
                        rd_accept = 1'b1;
                        state_d   = StRdrain;
                    end
                end
            end
            // Read-after-write: hold the read until every posted write has its B response.
            StRdrain: if (q_empty && (wstate_q == WStIdle)) state_d = StRaddr;
            StRaddr:  if (m_axi.arready) state_d = StRdata;
            StRdata:  if (m_axi.rvalid) state_d = StIdle;
            default:  state_d = StCalib;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StCalib;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= 1'b0;
            if (rd_accept) raddr_q <= req_addr;
            if ((state_q == StRdata) && m_axi.rvalid) begin
                rdata_q  <= m_axi.rdata;
                rvalid_q <= 1'b1;
            end
            // resp[1] covers both SLVERR and DECERR.
            if ((m_axi.bvalid && m_axi.bready && m_axi.bresp[1]) ||
                (m_axi.rvalid && m_axi.rready && m_axi.rresp[1])) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_rdata  = rdata_q;
    assign o_rvalid = rvalid_q;
    assign o_err    = err_q;

    // Write engine
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;

    always_comb begin
        wstate_d  = wstate_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        q_pop     = 1'b0;
        case (wstate_q)
            WStIdle: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (!q_empty) wstate_d = WStReq;
            end
            WStReq: begin
                if (m_axi.awvalid && m_axi.awready) aw_done_d = 1'b1;
                if (m_axi.wvalid && m_axi.wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          wstate_d  = WStResp;
            end
            WStResp: begin
                if (m_axi.bvalid) begin
                    q_pop    = 1'b1;
                    wstate_d = WStIdle;
                end
            end
            default: wstate_d = WStIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wstate_q  <= WStIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // AXI outputs; the queue head stays put until its B response pops it.
    assign m_axi.awaddr  = q_head[ENTRY_W-1 -: ADDR_W];
    assign m_axi.wdata   = q_head[STRB_W +: DATA_W];
    assign m_axi.wstrb   = q_head[STRB_W-1:0];
    assign m_axi.awvalid = (wstate_q == WStReq) && !aw_done_q;
    assign m_axi.wvalid  = (wstate_q == WStReq) && !w_done_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.bready  = (wstate_q == WStResp);

    assign m_axi.araddr  = raddr_q;
    assign m_axi.arvalid = (state_q == StRaddr);
    assign m_axi.rready  = (state_q == StRdata);

    assign m_axi.awid    = '0;
    assign m_axi.awlen   = '0;
    assign m_axi.awsize  = 3'(LSB);
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AXI_CACHE;
    assign m_axi.awprot  = '0;
    assign m_axi.awqos   = '0;
    assign m_axi.arid    = '0;
    assign m_axi.arlen   = '0;
    assign m_axi.arsize  = 3'(LSB);
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = AXI_CACHE;
    assign m_axi.arprot  = '0;
    assign m_axi.arqos   = '0;

endmodule

// File: tb/tb_dram_axi_bridge.sv
module tb_dram_axi_bridge;
    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned QDEPTH = 4;
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned LANES  = DATA_W / 32;
    localparam int unsigned LSB    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              calib = 1'b0;
    logic              rd_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [31:0]       addr = '0;
    logic [31:0]       data = '0;
    logic [3:0]        strb = '0;
    logic              busy;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;

    dram_axi_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_axi ();

    dram_axi_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_calib_done(calib),
        .i_rd_en     (rd_en),
        .i_wr_en     (wr_en),
        .i_addr      (addr),
        .i_data      (data),
        .i_wstrb     (strb),
        .o_busy      (busy),
        .o_rdata     (rdata),
        .o_rvalid    (rvalid),
        .o_err       (err),
        .m_axi       (m_axi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard queues and reference model (byte-addressed 32-bit word memory)
    logic [ADDR_W-1:0] exp_aw[$];
    logic [DATA_W-1:0] exp_wd[$];
    logic [BYTES-1:0]  exp_ws[$];
    logic [ADDR_W-1:0] exp_ar[$];
    logic [DATA_W-1:0] exp_rd[$];
    logic [31:0]       model_mem[int unsigned];
    int                wr_issued = 0;
    int                b_seen = 0;
    logic              err_exp = 1'b0;

    // Slave controls and state
    logic              hold_aw = 1'b0, hold_b = 1'b0, hold_r = 1'b0, err_next_b = 1'b0;
    logic [DATA_W-1:0] slv_mem[int unsigned];

    function automatic logic [ADDR_W-1:0] align(input logic [31:0] a);
        return ADDR_W'(a) & ~ADDR_W'(BYTES - 1);
    endfunction

    function automatic logic [DATA_W-1:0] model_beat(input logic [31:0] a);
        logic [DATA_W-1:0] b = '0;
        int unsigned base = int'(align(a)) / 4;
        for (int l = 0; l < LANES; l++)
            if (model_mem.exists(base + l)) b[l*32 +: 32] = model_mem[base + l];
        return b;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("busy_timeout", 256'(busy), 256'(0));
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [DATA_W-1:0] w;
        logic [BYTES-1:0]  ws = '0;
        logic [31:0]       cur;
        int unsigned       lane = (int'(ADDR_W'(a)) % BYTES) / 4;
        int unsigned       wi = int'(ADDR_W'(a)) / 4;
        for (int l = 0; l < LANES; l++) w[l*32 +: 32] = d;
        ws[lane*4 +: 4] = s;
        exp_aw.push_back(align(a));
        exp_wd.push_back(w);
        exp_ws.push_back(ws);
        cur = model_mem.exists(wi) ? model_mem[wi] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        model_mem[wi] = cur;
        wr_issued++;
    endtask

    // All driver tasks start and end at posedge+1.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wait_ready();
        model_write(a, d, s);
        addr = a; data = d; strb = s; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        wait_ready();
        exp_ar.push_back(align(a));
        exp_rd.push_back(model_beat(a));
        addr = a; rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic wait_quiet(input string nm);
        int n = 0;
        while (!(exp_aw.size() == 0 && exp_wd.size() == 0 && exp_ar.size() == 0 &&
                 exp_rd.size() == 0 && wr_issued == b_seen && !busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 256'(n >= 3000), 256'(0));
    endtask

    function automatic logic [5:0] valids();
        return {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, m_axi.bready, m_axi.rready, rvalid};
    endfunction

    task automatic reset_seq();
        rst = 1'b1; calib = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        exp_aw.delete(); exp_wd.delete(); exp_ws.delete(); exp_ar.delete(); exp_rd.delete();
        err_exp = 1'b0; wr_issued = 0; b_seen = 0;
        hold_aw = 1'b0; hold_b = 1'b0; hold_r = 1'b0; err_next_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) calib = 1'b1;
            @(negedge clk);
            chk("busy_before_calib", 256'(busy), 256'(1));
            chk("valids_before_calib", 256'(valids()), 256'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("busy_after_calib", 256'(busy), 256'(0));
        chk("rdata_reset", 256'(rdata), 256'(0));
        chk("err_reset", 256'(err), 256'(0));
        chk("valids_after_calib", 256'(valids()), 256'(0));
        @(posedge clk); #1;
        calib = 1'b0;  // later deassertion must be ignored
    endtask

    // AXI slave: handshakes sampled at negedge, responses driven at posedge+1.
    logic              got_aw = 1'b0, got_w = 1'b0, b_act = 1'b0, r_act = 1'b0;
    logic [ADDR_W-1:0] pend_aw, pend_ar;
    logic [DATA_W-1:0] pend_wd;
    logic [BYTES-1:0]  pend_ws;
    int                b_cnt = 0, r_cnt = 0;

    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [ADDR_W-1:0] aw_a, ar_a;
        logic [DATA_W-1:0] w_d, beat;
        logic [BYTES-1:0]  w_s;
        m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
        m_axi.bvalid = 1'b0; m_axi.bresp = 2'b00;
        m_axi.rvalid = 1'b0; m_axi.rresp = 2'b00; m_axi.rdata = '0;
        forever begin
            @(negedge clk);
            aw_hs = m_axi.awvalid && m_axi.awready; aw_a = m_axi.awaddr;
            w_hs  = m_axi.wvalid && m_axi.wready;   w_d = m_axi.wdata; w_s = m_axi.wstrb;
            b_hs  = m_axi.bvalid && m_axi.bready;
            ar_hs = m_axi.arvalid && m_axi.arready; ar_a = m_axi.araddr;
            r_hs  = m_axi.rvalid && m_axi.rready;
            @(posedge clk); #1;
            if (rst) begin
                got_aw = 1'b0; got_w = 1'b0; b_act = 1'b0; r_act = 1'b0;
                m_axi.bvalid = 1'b0; m_axi.rvalid = 1'b0;
                m_axi.awready = 1'b0; m_axi.wready = 1'b0; m_axi.arready = 1'b0;
                continue;
            end
            if (aw_hs) begin got_aw = 1'b1; pend_aw = aw_a; end
            if (w_hs)  begin got_w = 1'b1; pend_wd = w_d; pend_ws = w_s; end
            if (got_aw && got_w) begin
                beat = slv_mem.exists(int'(pend_aw >> LSB)) ? slv_mem[int'(pend_aw >> LSB)] : '0;
                for (int b = 0; b < BYTES; b++) if (pend_ws[b]) beat[b*8 +: 8] = pend_wd[b*8 +: 8];
                slv_mem[int'(pend_aw >> LSB)] = beat;
                got_aw = 1'b0; got_w = 1'b0; b_act = 1'b1; b_cnt = $urandom_range(0, 3);
            end
            if (b_hs) begin
                m_axi.bvalid = 1'b0; b_act = 1'b0; b_seen++;
                if (m_axi.bresp[1]) err_exp = 1'b1;
            end else if (b_act && !m_axi.bvalid && !hold_b) begin
                if (b_cnt == 0) begin
                    m_axi.bvalid = 1'b1;
                    m_axi.bresp  = err_next_b ? 2'b10 : 2'b00;
                    err_next_b   = 1'b0;
                end else b_cnt--;
            end
            if (ar_hs) begin r_act = 1'b1; pend_ar = ar_a; r_cnt = $urandom_range(0, 3); end
            if (r_hs) begin
                m_axi.rvalid = 1'b0; r_act = 1'b0;
                if (m_axi.rresp[1]) err_exp = 1'b1;
            end else if (r_act && !m_axi.rvalid && !hold_r) begin
                if (r_cnt == 0) begin
                    m_axi.rvalid = 1'b1;
                    m_axi.rresp  = 2'b00;
                    m_axi.rdata  = slv_mem.exists(int'(pend_ar >> LSB)) ?
                                   slv_mem[int'(pend_ar >> LSB)] : '0;
                end else r_cnt--;
            end
            m_axi.awready = !hold_aw && ($urandom_range(0, 2) != 0);
            m_axi.wready  = ($urandom_range(0, 2) != 0);
            m_axi.arready = ($urandom_range(0, 1) != 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer.
    localparam logic [28:0] TIEOFF = {4'd0, 8'd0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0};
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_axi.awvalid && m_axi.awready) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", 256'(m_axi.awaddr), 256'(0) - 1);
                    else chk("awaddr", 256'(m_axi.awaddr), 256'(exp_aw.pop_front()));
                    chk("aw_tieoff", 256'({m_axi.awid, m_axi.awlen, m_axi.awsize, m_axi.awburst,
                        m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos}), 256'(TIEOFF));
                end
                if (m_axi.wvalid && m_axi.wready) begin
                    if (exp_wd.size() == 0) chk("w_unexpected", 256'(m_axi.wdata), 256'(0) - 1);
                    else begin
                        chk("wdata", 256'(m_axi.wdata), 256'(exp_wd.pop_front()));
                        chk("wstrb", 256'(m_axi.wstrb), 256'(exp_ws.pop_front()));
                    end
                    chk("wlast", 256'(m_axi.wlast), 256'(1));
                end
                if (m_axi.arvalid && m_axi.arready) begin
                    chk("raw_order", 256'(wr_issued - b_seen), 256'(0));
                    if (exp_ar.size() == 0) chk("ar_unexpected", 256'(m_axi.araddr), 256'(0) - 1);
                    else chk("araddr", 256'(m_axi.araddr), 256'(exp_ar.pop_front()));
                    chk("ar_tieoff", 256'({m_axi.arid, m_axi.arlen, m_axi.arsize, m_axi.arburst,
                        m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos}), 256'(TIEOFF));
                end
                if (rvalid) begin
                    if (exp_rd.size() == 0) chk("rvalid_unexpected", 256'(rdata), 256'(0) - 1);
                    else chk("rdata", 256'(rdata), 256'(exp_rd.pop_front()));
                    chk("err_at_read", 256'(err), 256'(err_exp));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int ok;
        reset_seq();

        // Single write with lane placement
        do_write(32'h14, 32'hDEADBEEF, 4'hF);
        wait_quiet("drain_single_write");

        // Queue fill: AW stalled, five back-to-back writes, only four fit
        hold_aw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 32'h200 + 32'(i) * 32'h14;
            if (i < 4) model_write(a, 32'hA000_0000 + 32'(i), 4'hF);
            addr = a; data = 32'hA000_0000 + 32'(i); strb = 4'hF; wr_en = 1'b1;
            @(negedge clk);
            chk(i < 4 ? "queue_not_full" : "queue_full_busy", 256'(busy), 256'(i == 4));
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 hold_aw = 1'b0;
        wait_quiet("drain_queue_fill");

        // Read-after-write: read must wait for the B handshake
        hold_b = 1'b1;
        do_write(32'h100, 32'h1234_5678, 4'hF);
        do_read(32'h100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ar_held_for_b", 256'(m_axi.arvalid), 256'(0));
            @(posedge clk); #1;
        end
        hold_b = 1'b0;
        wait_quiet("drain_raw");

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            a = {4'($urandom), 18'd0, 10'($urandom)};
            if ($urandom_range(0, 9) < 3) do_read(a);
            else do_write(a, $urandom, 4'($urandom));
        end
        wait_quiet("drain_random");

        // Error response is sticky across an OKAY read
        err_next_b = 1'b1;
        do_write(32'h40, 32'hCAFE_F00D, 4'h3);
        do_read(32'h40);
        wait_quiet("drain_err");
        chk("err_sticky", 256'(err), 256'(1));
        do_read(32'h14);
        wait_quiet("drain_err_read2");
        chk("err_still_set", 256'(err), 256'(1));

        // Reset while waiting in RDATA
        hold_r = 1'b1;
        do_read(32'h100);
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (m_axi.rready) ok = 1;
        end
        chk("reach_rdata", 256'(ok), 256'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_arvalid", 256'(m_axi.arvalid), 256'(0));
        chk("rst_rready", 256'(m_axi.rready), 256'(0));
        chk("rst_rvalid", 256'(rvalid), 256'(0));
        chk("rst_busy", 256'(busy), 256'(1));
        reset_seq();
        do_write(32'h3C, 32'h0BAD_BEEF, 4'hC);
        do_read(32'h30);
        wait_quiet("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
